// File: rtl/mips_loader_pkg.sv
// ============================================================================
//  mips_loader_pkg
//  Shared types and stream-header field positions for mips_prog_loader.
//  Rev 1.0
// ============================================================================
`default_nettype none

package mips_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int LAST_BIT  = 31;
    localparam int CNT_MSB   = 30;
    localparam int CNT_LSB   = 16;
    localparam int BASE_MSB  = 15;
    localparam int BASE_LSB  = 0;
    localparam int MAX_WORDS = 1024;

endpackage

`default_nettype wire

// File: rtl/mips_prog_loader.sv
// ============================================================================
//  mips_prog_loader
//  Loads a framed, checksummed word stream into MIPS_32 memory, then releases
//  the processor from halt with PC cleared.
//  Rev 1.0
// ============================================================================
`default_nettype none

module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = $clog2(MAX_WORDS),
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_halt,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = CNT_MSB - CNT_LSB + 1;
    localparam int BASE_W = BASE_MSB - BASE_LSB + 1;
    localparam logic [16:0] END_LIMIT = 17'(2 ** ADDR_W);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   xor_q, xor_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                start_q, start_d;

    logic                w_acc;
    logic [CNT_W-1:0]    w_hdr_cnt;
    logic [BASE_W-1:0]   w_hdr_base;
    logic [16:0]         w_hdr_end;
    logic                w_hdr_bad;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_RUN);
    assign err       = (state_q == ST_ERR);
    assign cpu_halt  = (state_q != ST_RUN);
    assign cpu_start = start_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign w_acc      = in_valid && in_ready;
    assign w_hdr_cnt  = in_data[CNT_MSB:CNT_LSB];
    assign w_hdr_base = in_data[BASE_MSB:BASE_LSB];
    // One 17-bit add-compare covers both the segment end and base overflow.
    assign w_hdr_end  = {1'b0, w_hdr_base} + {2'b00, w_hdr_cnt};
    assign w_hdr_bad  = (w_hdr_cnt == '0) || ((w_hdr_base >> ADDR_W) != '0) ||
                        (w_hdr_end > END_LIMIT);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_hdr_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        last_d  = in_data[LAST_BIT];
                        rem_d   = w_hdr_cnt;
                        ptr_d   = w_hdr_base[ADDR_W-1:0];
                        xor_d   = in_data;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_acc) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    xor_d   = xor_q ^ in_data;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_acc) begin
                    if (in_data != xor_q) begin
                        state_d = ST_ERR;
                    end else if (last_q) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
            rem_q   <= '0;
            ptr_q   <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
// ============================================================================
//  tb_mips_prog_loader
//  Stream-level reference model bench for mips_prog_loader.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_prog_loader;

    localparam int AW    = 10;
    localparam int MEMSZ = 1024;
    localparam int K_HDR = 0;
    localparam int K_PAY = 1;
    localparam int K_CHK = 2;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = 32'h0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_halt;
    logic          cpu_start;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk1 = ~clk1;

    mips_prog_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_halt  (cpu_halt),
        .cpu_start (cpu_start),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] strm[$];
    logic [31:0] pq[$];
    int          kind[256];
    int          waddr[256];
    int          term_idx;
    int          term_run;
    int          acc;
    int          wr_count;
    logic [31:0] exp_mem[MEMSZ];
    logic [31:0] dut_mem[MEMSZ];

    logic [31:0] prog[11] = '{32'h280a00c8, 32'h28020001, 32'h28030002, 32'h00432020,
                              32'h00832822, 32'h0ca50000, 32'h2ca6000a, 32'h34c70005,
                              32'hac070010, 32'h8c080010, 32'hfc000000};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Walk the whole stream segment by segment and decide, per word, what it is,
    // where it lands, and at which accepted word the loader must stop for good.
    task automatic build_plan();
        int i, n, base, j;
        logic [31:0] hdr, x;
        for (int k = 0; k < 256; k++) begin
            kind[k]  = K_HDR;
            waddr[k] = 0;
        end
        term_idx = -1;
        term_run = 0;
        acc      = 0;
        wr_count = 0;
        i        = 0;
        while (i < strm.size() && term_idx < 0) begin
            hdr  = strm[i];
            n    = int'(hdr[30:16]);
            base = int'(hdr[15:0]);
            if (n == 0 || base + n > MEMSZ) begin
                term_idx = i;
                break;
            end
            x = hdr;
            for (int k = 0; k < n; k++) begin
                kind[i+1+k]  = K_PAY;
                waddr[i+1+k] = base + k;
                x = x ^ strm[i+1+k];
            end
            j = i + n + 1;
            kind[j] = K_CHK;
            if (strm[j] != x) begin
                term_idx = j;
            end else if (hdr[31]) begin
                term_idx = j;
                term_run = 1;
            end
            i = j + 1;
        end
    endtask

    task automatic add_seg(input logic [31:0] hdr, input logic bad);
        logic [31:0] x;
        x = hdr;
        strm.push_back(hdr);
        foreach (pq[k]) begin
            strm.push_back(pq[k]);
            x = x ^ pq[k];
        end
        strm.push_back(bad ? ~x : x);
        pq.delete();
    endtask

    // Called at a falling edge: drive one cycle, check right after the rising edge.
    task automatic step(input logic v, input logic [31:0] d);
        logic pend, term, ewe;
        int   j;
        in_valid = v;
        in_data  = d;
        pend = v && !(term_idx >= 0 && acc > term_idx);
        j    = acc;
        @(posedge clk1);
        #1;
        if (pend) acc++;
        term = (term_idx >= 0) && (acc > term_idx);
        ewe  = pend && (kind[j] == K_PAY);
        cmp("mem_we", 32'(mem_we), 32'(ewe));
        if (ewe) begin
            cmp("mem_addr", 32'(mem_addr), 32'(waddr[j]));
            cmp("mem_wdata", mem_wdata, strm[j]);
            exp_mem[waddr[j]] = strm[j];
        end
        if (mem_we === 1'b1) begin
            dut_mem[mem_addr] = mem_wdata;
            wr_count++;
        end
        cmp("cpu_start", 32'(cpu_start), 32'(pend && (j == term_idx) && (term_run == 1)));
        cmp("in_ready", 32'(in_ready), 32'(!term));
        cmp("done", 32'(done), 32'(term && term_run == 1));
        cmp("err", 32'(err), 32'(term && term_run == 0));
        cmp("cpu_halt", 32'(cpu_halt), 32'(!(term && term_run == 1)));
        cmp("busy", 32'(busy), 32'(!term && kind[acc] != K_HDR));
        @(negedge clk1);
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        cmp({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        cmp({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        cmp({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        cmp({tag, "_cpu_halt"}, 32'(cpu_halt), 32'd1);
        cmp({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
        cmp({tag, "_busy"}, 32'(busy), 32'd0);
        cmp({tag, "_done"}, 32'(done), 32'd0);
        cmp({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 32'h0;
        rst_n    = 1'b0;
        #1;
        check_reset("rst_async");
        @(posedge clk1);
        #1;
        check_reset("rst_held");
        @(negedge clk1);
        rst_n = 1'b1;
        acc   = 0;
    endtask

    task automatic run_stream(input int gap, input int stop_at);
        int budget;
        budget = 0;
        while (!(term_idx >= 0 && acc > term_idx) && acc < strm.size() && acc < stop_at) begin
            if (budget >= 1000) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_timeout: accepted %0d of %0d words", acc, strm.size());
                break;
            end
            if (int'($urandom_range(99)) < gap) step(1'b0, $urandom);
            else step(1'b1, strm[acc]);
            budget++;
        end
        if (term_idx >= 0 && acc > term_idx) repeat (3) step(1'b1, $urandom);
        else if (acc >= strm.size()) repeat (2) step(1'b0, 32'h0);
    endtask

    task automatic load_program();
        strm.delete();
        foreach (prog[k]) pq.push_back(prog[k]);
        add_seg(32'h800B0000, 1'b0);
        build_plan();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int npay, nseg, n, base, mism;
        logic [31:0] hdr;
        for (int k = 0; k < MEMSZ; k++) begin
            exp_mem[k] = 32'h0;
            dut_mem[k] = 32'h0;
        end
        term_idx = -1;
        term_run = 0;
        acc      = 0;
        @(negedge clk1);
        do_reset();

        // Single-segment program load, no gaps
        load_program();
        npay = 0;
        for (int k = 0; k < 256; k++) if (kind[k] == K_PAY) npay++;
        cmp("prog_plan_writes", 32'(npay), 32'd11);
        cmp("prog_plan_term", 32'(term_idx), 32'd12);
        run_stream(0, 1000);
        cmp("prog_writes", 32'(wr_count), 32'd11);
        cmp("prog_done", 32'(done), 32'd1);
        cmp("prog_mem10", dut_mem[10], 32'hfc000000);

        // Two segments
        do_reset();
        strm.delete();
        pq.push_back(32'h280a00c8);
        add_seg(32'h00010000, 1'b0);
        pq.push_back(32'h00000007);
        add_seg(32'h800100C8, 1'b0);
        build_plan();
        cmp("two_plan_term", 32'(term_idx), 32'd5);
        run_stream(0, 1000);
        cmp("two_mem200", dut_mem[200], 32'h7);
        cmp("two_mem0", dut_mem[0], 32'h280a00c8);

        // Bad checksum
        do_reset();
        strm = {32'h80020010, 32'h1, 32'h2, 32'h0};
        build_plan();
        cmp("bad_plan_term", 32'(term_idx), 32'd3);
        run_stream(0, 1000);
        cmp("bad_writes", 32'(wr_count), 32'd2);
        cmp("bad_err", 32'(err), 32'd1);
        cmp("bad_mem17", dut_mem[17], 32'h2);

        // Range overflow and zero count
        do_reset();
        strm = {32'h800203FF, 32'h1, 32'h2, 32'h0};
        build_plan();
        cmp("range_plan_term", 32'(term_idx), 32'd0);
        run_stream(0, 1000);
        cmp("range_writes", 32'(wr_count), 32'd0);
        do_reset();
        strm = {32'h80000005, 32'h80000005};
        build_plan();
        run_stream(0, 1000);
        cmp("zero_writes", 32'(wr_count), 32'd0);
        cmp("zero_err", 32'(err), 32'd1);

        // Program load with random gaps
        do_reset();
        load_program();
        run_stream(40, 1000);
        cmp("gap_done", 32'(done), 32'd1);

        // Reset after 3 payload words, then full reload
        do_reset();
        load_program();
        run_stream(0, 4);
        do_reset();
        build_plan();
        run_stream(25, 1000);
        cmp("reload_writes", 32'(wr_count), 32'd11);

        // Random multi-segment streams, including overlaps and faulty frames
        for (int t = 0; t < 25; t++) begin
            do_reset();
            strm.delete();
            nseg = int'($urandom_range(1, 3));
            for (int s = 0; s < nseg; s++) begin
                n    = int'($urandom_range(1, 6));
                base = int'($urandom_range(0, MEMSZ - n));
                case ($urandom_range(11))
                    0: n = 0;
                    1: base = int'($urandom_range(MEMSZ - n + 1, MEMSZ - 1));
                    2: base = int'($urandom_range(MEMSZ, 65535));
                    default: ;
                endcase
                hdr = {(s == nseg - 1), 15'(n), 16'(base)};
                for (int k = 0; k < n; k++) pq.push_back($urandom);
                add_seg(hdr, ($urandom_range(9) == 0));
            end
            build_plan();
            run_stream(int'($urandom_range(0, 50)), 1000);
        end

        mism = 0;
        for (int k = 0; k < MEMSZ; k++) if (dut_mem[k] !== exp_mem[k]) mism++;
        cmp("mem_image", 32'(mism), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_prog_loader.md
# mips_prog_loader

Boot-time program loader sitting directly upstream of the MIPS_32 pipeline. It accepts a framed word stream on a valid/ready port and writes the words into the processor's unified instruction/data memory. It holds the processor halted until the stream checks out, then releases it with PC cleared to 0. It replaces hand-written hierarchical memory pokes with a synthesizable, checksummed load path.

## Interface
- ADDR_W, 10: memory word-address width (1024-word memory).
- DATA_W, 32: word width; fixed at 32.
- clk1  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream word present.
- in_data  in  32  stream word.
- in_ready  out  1  loader accepts word; transfer when in_valid & in_ready.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- cpu_halt  out  1  drives processor HALTED; 1 until release.
- cpu_start  out  1  one-cycle pulse: processor clears PC and TAKEN_BRANCH.
- busy  out  1  segment in progress (LOAD or CHECK).
- done  out  1  sticky: all segments loaded and verified.
- err  out  1  sticky: framing, range or checksum error.

## Operation
- Stream framing is one or more segments. Each segment is a header, then N payload words, then a checksum word.
- Header fields:
  - [31] LAST: final segment.
  - [30:16] N: word count.
  - [15:0] BASE: word address.
- Checksum word = XOR of the header and all N payload words.
- States:
  - IDLE: in_ready=1. On header accept:
    - If N==0, or BASE[15:ADDR_W]!=0, or BASE+N > 2**ADDR_W (computed at 17 bits): go to ERR.
    - Otherwise latch LAST, N, BASE, set running XOR = header, go to LOAD.
  - LOAD: in_ready=1. Each accepted word is written to BASE+k (k = 0..N-1) and XORed into the running value. After word N-1, go to CHECK.
  - CHECK: in_ready=1. Accept one word.
    - If it equals the running XOR and LAST=0: go to IDLE.
    - If it equals the running XOR and LAST=1: go to RUN.
    - Otherwise: go to ERR.
  - RUN: in_ready=0, cpu_halt=0, done=1. Terminal until reset.
  - ERR: in_ready=0, cpu_halt=1, err=1. Terminal until reset. Words already written are not erased.
- Segments may overlap; a later write to the same address wins.
- Words with in_valid=1 while in_ready=0 are not consumed. The loader ignores them and does not stall.

## Timing
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_halt=1, cpu_start=0, busy=0, done=0, err=0.
  - State = IDLE.
- mem_we, mem_addr and mem_wdata are registered. Write appears exactly 1 cycle after the accepting edge, with mem_we high for exactly 1 cycle per payload word. Back-to-back accepts give back-to-back writes.
- in_ready is a function of state only, with no combinational path from in_valid.
- One word is accepted per cycle maximum. Gaps in in_valid simply hold state.
- On a good LAST checksum accepted at edge t:
  - At t+1: state=RUN, cpu_halt falls, cpu_start=1, done=1.
  - At t+2: cpu_start returns to 0.
- Error is flagged at the edge after the offending header or checksum word: err=1, in_ready=0.
- An rst_n assertion at any point (including mid-LOAD) immediately forces the reset values. A pending mem_we is dropped. The stream restarts from a header.

## Structure
- Shared package mips_loader_pkg holds:
  - State enum.
  - Header field positions (LAST_BIT, CNT_MSB/LSB, BASE_MSB/LSB).
  - MAX_WORDS constant.
- Single module with no sub-modules. The range check is one 17-bit add-compare.
- MIPS_32 integration: mem_* go to the memory write port, cpu_halt drives HALTED, and cpu_start forces PC=0 and TAKEN_BRANCH=0.

## Test plan
- Program load: header 0x800B0000, then 11 words 0x280a00c8 … 0xfc000000, then correct XOR. Expect 11 writes to addr 0..10, then cpu_start pulse, cpu_halt=0, done=1, err=0.
- Two segments:
  - Segment 1: header 0x00010000 + 0x280a00c8 + XOR.
  - Segment 2: header 0x800100C8 + 0x00000007 + XOR.
  - Expect Mem[200]=7 and Mem[0] written. done only after segment 2. cpu_halt stays 1 between segments.
- Bad checksum: header 0x80020010, payload 1, 2, checksum 0. Expect writes to 16 and 17, then err=1, in_ready=0, cpu_halt=1, no cpu_start.
- Range and zero count:
  - Header 0x800203FF: err next cycle, zero writes.
  - After reset, header 0x80000005: err, zero writes.
- Backpressure and gaps: random in_valid gaps on the program load. Writes stay in order, each 1 cycle after accept. Words sent in RUN are ignored, with mem_we=0.
- Reset mid-LOAD: after 3 of 11 words, pulse rst_n low. Outputs return to reset values within the same low phase. A full reload then succeeds.
